// File: rtl/truth_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, vector count
// and counter widths.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int IDX_W       = 2;
  localparam int CNT_W       = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/sweep_settle_timer.sv
// Counts how long the current input vector has been held; expired marks the
// final hold cycle so the FSM can move to sampling on the next edge.
module sweep_settle_timer
  import truth_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives the four two-input vectors into a gate under test, captures its output
// per vector into table_out and compares the result against a reference table.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  output logic       a_out,
  output logic       b_out,
  input  logic       s_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       match
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       table_q, table_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic             settle_expired;

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != DRIVE),
    .enable  (state_q == DRIVE),
    .expired (settle_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (settle_expired) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == LAST_IDX) ? FINISH : DRIVE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start is only honoured from IDLE, so requests during a sweep or in FINISH drop out here.
  always_comb begin
    idx_d   = idx_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          table_d = 4'b0000;
          busy_d  = 1'b1;
        end
      end
      SAMPLE: begin
        table_d[idx_q] = s_in;
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + 1'b1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        match_d = (table_q == expected);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      table_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign a_out     = idx_q[1];
  assign b_out     = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=3) driving behavioural
// gates, checked cycle by cycle against a timing/table model of a sweep.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, start3 = 1'b0;
  logic [3:0] exp1 = 4'd0, exp3 = 4'd0;
  logic       a1, b1, s1, busy1, done1, match1;
  logic       a3, b3, s3, busy3, done3, match3;
  logic [3:0] tbl1, tbl3;

  logic       chain1 = 1'b1, chain3 = 1'b1;
  logic [3:0] tt1 = 4'd0, tt3 = 4'd0;
  logic       or3;

  // Gate under test: a AND NOT b, or an arbitrary table for random sweeps.
  assign s1  = chain1 ? (a1 & ~b1) : tt1[{a1, b1}];
  // NOR fed by an OR stage: behaves as NOR(a, b).
  assign or3 = a3 | b3;
  assign s3  = chain3 ? ~(or3 | (a3 & b3)) : tt3[{a3, b3}];

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1),
    .a_out(a1), .b_out(b1), .s_in(s1), .busy(busy1), .done(done1),
    .table_out(tbl1), .match(match1)
  );

  truth_table_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3),
    .a_out(a3), .b_out(b3), .s_in(s3), .busy(busy3), .done(done3),
    .table_out(tbl3), .match(match3)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic pm1 = 1'b0, pm3 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic set_start(input bit use3, input logic v);
    if (use3) start3 = v; else start1 = v;
  endtask

  task automatic set_exp(input bit use3, input logic [3:0] v);
    if (use3) exp3 = v; else exp1 = v;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy1"}, 32'(busy1), 32'd0);
    chk({tag, " done1"}, 32'(done1), 32'd0);
    chk({tag, " tbl1"},  32'(tbl1),  32'd0);
    chk({tag, " match1"}, 32'(match1), 32'd0);
    chk({tag, " ab1"},   32'({a1, b1}), 32'd0);
    chk({tag, " busy3"}, 32'(busy3), 32'd0);
    chk({tag, " done3"}, 32'(done3), 32'd0);
    chk({tag, " tbl3"},  32'(tbl3),  32'd0);
    chk({tag, " ab3"},   32'({a3, b3}), 32'd0);
  endtask

  // One full sweep with per-cycle checks. c counts rising edges after the accept edge.
  task automatic do_sweep(input bit use3, input logic [3:0] gtt, input logic [3:0] expv,
                          input bit extra, input bit fin_start, input string name);
    int         s;
    int         lat;
    int         idx;
    int         last_c;
    logic       pm;
    logic [3:0] mask;
    logic [3:0] junk;
    logic       oa, ob, obusy, odone, omatch;
    logic [3:0] otbl;
    int         done_cnt;
    s        = use3 ? 3 : 1;
    lat      = 4 * (s + 1) + 1;
    pm       = use3 ? pm3 : pm1;
    last_c   = fin_start ? lat : lat + 1;
    done_cnt = 0;
    junk     = expv ^ 4'($urandom_range(1, 15));
    set_exp(use3, expv);
    set_start(use3, 1'b1);
    @(posedge clk);
    #1;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      oa     = use3 ? a3 : a1;
      ob     = use3 ? b3 : b1;
      obusy  = use3 ? busy3 : busy1;
      odone  = use3 ? done3 : done1;
      omatch = use3 ? match3 : match1;
      otbl   = use3 ? tbl3 : tbl1;
      idx    = (c / (s + 1) > 3) ? 3 : c / (s + 1);
      mask   = 4'd0;
      for (int v = 0; v < 4; v++) begin
        if ((v + 1) * (s + 1) <= c) mask[v] = 1'b1;
      end
      if (odone === 1'b1) done_cnt++;
      chk($sformatf("%s vec c%0d", name, c), 32'({oa, ob}), 32'(idx[1:0]));
      chk($sformatf("%s busy c%0d", name, c), 32'(obusy), 32'(c < lat));
      chk($sformatf("%s done c%0d", name, c), 32'(odone), 32'(c == lat));
      chk($sformatf("%s table c%0d", name, c), 32'(otbl), 32'(gtt & mask));
      chk($sformatf("%s match c%0d", name, c), 32'(omatch),
          32'((c < lat) ? pm : (gtt == expv)));
      if (c == 0) begin
        set_start(use3, 1'b0);
        set_exp(use3, junk);
      end
      if (extra && (c == 2 || c == 5)) set_start(use3, 1'b1);
      if (extra && (c == 3 || c == 6)) set_start(use3, 1'b0);
      if (c == lat - 1) begin
        set_exp(use3, expv);
        if (fin_start) set_start(use3, 1'b1);
      end
    end
    chk({name, " done count"}, 32'(done_cnt), 32'd1);
    if (use3) pm3 = (gtt == expv); else pm1 = (gtt == expv);
    $display("sweep %-12s settle=%0d gate=%b expected=%b table=%b match=%0d",
             name, s, gtt, expv, use3 ? tbl3 : tbl1, use3 ? match3 : match1);
  endtask

  initial begin
    logic [3:0] gtt;
    logic [3:0] expv;
    bit         use3;

    // Reset must act without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    do_sweep(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, "andn_match");
    do_sweep(1'b0, 4'b0100, 4'b1110, 1'b0, 1'b0, "andn_miss");
    do_sweep(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, "andn_rematch");
    do_sweep(1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, "extra_start");

    // Reset in cycle 5 of a sweep aborts it with no done pulse.
    start1 = 1'b1;
    exp1   = 4'b0100;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mid_reset done held", 32'(done1), 32'd0);
      chk("mid_reset busy held", 32'(busy1), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pm1   = 1'b0;
    pm3   = 1'b0;
    $display("mid-sweep reset applied and released");
    do_sweep(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, "post_reset");

    do_sweep(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "nor_settle3");

    // start held through FINISH is ignored, then accepted from IDLE.
    do_sweep(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b1, "fin_start");
    do_sweep(1'b0, 4'b0100, 4'b1110, 1'b0, 1'b0, "after_fin");

    chain1 = 1'b0;
    chain3 = 1'b0;
    for (int it = 0; it < 8; it++) begin
      use3 = it[0];
      gtt  = 4'($urandom);
      expv = ($urandom_range(0, 1) == 1) ? gtt : 4'($urandom);
      if (use3) tt3 = gtt; else tt1 = gtt;
      do_sweep(use3, gtt, expv, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
